// File: rtl/bpsk_bit_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bpsk_bit_sequencer_if : byte stream in, bit/carrier-index stream out
// Rev 1.0
// ---------------------------------------------------------------------------
interface bpsk_bit_sequencer_if #(
  parameter int WAVELENGTH = 16
);
  localparam int IDX_W = $clog2(WAVELENGTH) + 1;

  logic [7:0]       in_data;
  logic             in_last;
  logic             in_valid;
  logic             in_ready;
  logic             data;
  logic [IDX_W-1:0] index;
  logic             active;
  logic             underrun;

  modport master (
    output in_data, in_last, in_valid,
    input  in_ready, data, index, active, underrun
  );

  modport slave (
    input  in_data, in_last, in_valid,
    output in_ready, data, index, active, underrun
  );
endinterface
`default_nettype wire

// File: rtl/bpsk_bit_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bpsk_bit_sequencer : preamble + MSB-first byte serializer, carrier aligned
// Rev 1.0
// ---------------------------------------------------------------------------
module bpsk_bit_sequencer #(
  parameter int         WAVELENGTH     = 16,
  parameter int         CYCLES_PER_BIT = 4,
  parameter int         PREAMBLE_BYTES = 2,
  parameter logic [7:0] PREAMBLE_BYTE  = 8'h55
) (
  input  logic                   clk,
  input  logic                   rst,
  bpsk_bit_sequencer_if.slave    bus
);
  localparam int IDX_W = $clog2(WAVELENGTH) + 1;
  localparam int CYC_W = (CYCLES_PER_BIT > 1) ? $clog2(CYCLES_PER_BIT) : 1;
  localparam int PRE_W = (PREAMBLE_BYTES > 0) ? $clog2(PREAMBLE_BYTES + 1) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(WAVELENGTH - 1);
  localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYCLES_PER_BIT - 1);
  localparam logic [PRE_W-1:0] PRE_COUNT = PRE_W'(PREAMBLE_BYTES);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]       shifter_q, shifter_d;
  logic             cur_last_q, cur_last_d;
  logic             hold_full_q, hold_full_d;
  logic [7:0]       hold_byte_q, hold_byte_d;
  logic             hold_last_q, hold_last_d;
  logic             data_q, data_d;
  logic             active_q, active_d;
  logic             underrun_q, underrun_d;

  logic wrap, bit_end, byte_end, in_ready, accept;

  assign in_ready = ~hold_full_q & ~rst;
  assign accept   = bus.in_valid & in_ready;
  assign wrap     = (index_q == IDX_LAST);
  assign bit_end  = wrap && (cyc_q == CYC_LAST);
  assign byte_end = bit_end && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    bit_cnt_d   = bit_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    shifter_d   = shifter_q;
    cur_last_d  = cur_last_q;
    hold_full_d = hold_full_q;
    hold_byte_d = hold_byte_q;
    hold_last_d = hold_last_q;
    active_d    = active_q;
    underrun_d  = 1'b0;

    index_d = wrap ? '0 : index_q + 1'b1;
    if (wrap) begin
      cyc_d = (cyc_q == CYC_LAST) ? '0 : cyc_q + 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        // Frames only start on a carrier-cycle boundary.
        if (hold_full_q && wrap) begin
          cyc_d     = '0;
          bit_cnt_d = 3'd0;
          active_d  = 1'b1;
          if (PREAMBLE_BYTES > 0) begin
            shifter_d  = PREAMBLE_BYTE;
            cur_last_d = 1'b0;
            pre_cnt_d  = PRE_W'(1);
            state_d    = ST_PREAMBLE;
          end else begin
            shifter_d   = hold_byte_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            state_d     = ST_DATA;
          end
        end
      end
      ST_PREAMBLE: begin
        if (bit_end) begin
          shifter_d = {shifter_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (byte_end) begin
          if (pre_cnt_q < PRE_COUNT) begin
            shifter_d = PREAMBLE_BYTE;
            pre_cnt_d = pre_cnt_q + 1'b1;
          end else begin
            shifter_d   = hold_byte_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
            state_d     = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          shifter_d = {shifter_q[6:0], 1'b0};
          bit_cnt_d = bit_cnt_q + 1'b1;
        end
        if (byte_end) begin
          if (cur_last_q) begin
            active_d = 1'b0;
            state_d  = ST_IDLE;
          end else if (hold_full_q) begin
            shifter_d   = hold_byte_q;
            cur_last_d  = hold_last_q;
            hold_full_d = 1'b0;
          end else begin
            active_d   = 1'b0;
            underrun_d = 1'b1;
            state_d    = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // in_ready is low while full, so this never collides with a transfer.
    if (accept) begin
      hold_full_d = 1'b1;
      hold_byte_d = bus.in_data;
      hold_last_d = bus.in_last;
    end

    data_d = active_d & shifter_d[7];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      index_q     <= '0;
      cyc_q       <= '0;
      bit_cnt_q   <= 3'd0;
      pre_cnt_q   <= '0;
      shifter_q   <= 8'h00;
      cur_last_q  <= 1'b0;
      hold_full_q <= 1'b0;
      hold_byte_q <= 8'h00;
      hold_last_q <= 1'b0;
      data_q      <= 1'b0;
      active_q    <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      index_q     <= index_d;
      cyc_q       <= cyc_d;
      bit_cnt_q   <= bit_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      shifter_q   <= shifter_d;
      cur_last_q  <= cur_last_d;
      hold_full_q <= hold_full_d;
      hold_byte_q <= hold_byte_d;
      hold_last_q <= hold_last_d;
      data_q      <= data_d;
      active_q    <= active_d;
      underrun_q  <= underrun_d;
    end
  end

  assign bus.in_ready = in_ready;
  assign bus.data     = data_q;
  assign bus.index    = index_q;
  assign bus.active   = active_q;
  assign bus.underrun = underrun_q;

endmodule
`default_nettype wire
